// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IACC = 3'd1,
    DACC = 3'd2,
    IRSP = 3'd3,
    DRSP = 3'd4
  } arb_state_t;

  localparam int AW_DEF          = 32;
  localparam int DW_DEF          = 32;
  localparam int MAX_DSTREAK_DEF = 4;
  localparam int TIMEOUT_DEF     = 64;

  function automatic logic is_acc(input arb_state_t s);
    return (s == IACC) || (s == DACC);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: counts cycles spent waiting for MemAck and flags the last allowed cycle.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_r;
  logic          expired_s;

  assign expired_s = (count_r == LAST);
  assign expired   = expired_s;

  // Cycle counter; holds at LAST so a stuck state cannot wrap it
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && !expired_s) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and the
// memory stage, sequencing grant / bus hold / MemAck wait / one-cycle response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          IReqF,
  input  logic [AW-1:0] IAddrF,
  output logic [DW-1:0] InstrF,
  output logic          IReadyF,
  input  logic          DReqM,
  input  logic          DWeM,
  input  logic [AW-1:0] DAddrM,
  input  logic [DW-1:0] DWDataM,
  output logic [DW-1:0] DRDataM,
  output logic          DReadyM,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  input  logic          MemAck,
  output logic          StallMemF,
  output logic          StallMemM,
  output logic          MemErr
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  arb_state_t    state_r, state_s;
  logic          grant_d_s, grant_i_s, expired_s;
  logic [SW-1:0] dstreak_r, dstreak_s;

  logic          mem_req_r, mem_req_s;
  logic          mem_we_r, mem_we_s;
  logic [AW-1:0] mem_addr_r, mem_addr_s;
  logic [DW-1:0] mem_wdata_r, mem_wdata_s;
  logic [DW-1:0] instr_r, instr_s;
  logic [DW-1:0] drdata_r, drdata_s;
  logic          iready_r, iready_s;
  logic          dready_r, dready_s;
  logic          mem_err_r, mem_err_s;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .Reset   (Reset),
    .clr     (grant_d_s | grant_i_s),
    .en      (is_acc(state_r)),
    .expired (expired_s)
  );

  // State register
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and grant decision; data normally wins to let the older instruction drain
  always_comb begin
    state_s   = state_r;
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (DReqM && (!IReqF || (dstreak_r < STREAK_MAX))) begin
          grant_d_s = 1'b1;
          state_s   = DACC;
        end else if (IReqF) begin
          grant_i_s = 1'b1;
          state_s   = IACC;
        end else begin
          state_s   = IDLE;
        end
      end
      IACC: begin
        if (MemAck || expired_s) begin
          state_s = IRSP;
        end else begin
          state_s = IACC;
        end
      end
      DACC: begin
        if (MemAck || expired_s) begin
          state_s = DRSP;
        end else begin
          state_s = DACC;
        end
      end
      IRSP:    state_s = IDLE;
      DRSP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the bus, response and streak registers
  always_comb begin
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    instr_s     = instr_r;
    drdata_s    = drdata_r;
    iready_s    = 1'b0;
    dready_s    = 1'b0;
    mem_err_s   = 1'b0;
    dstreak_s   = dstreak_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          mem_req_s   = 1'b1;
          mem_we_s    = DWeM;
          mem_addr_s  = DAddrM;
          mem_wdata_s = DWDataM;
          if (IReqF && (dstreak_r != STREAK_MAX)) begin
            dstreak_s = dstreak_r + STREAK_ONE;
          end else begin
            dstreak_s = dstreak_r;
          end
        end else if (grant_i_s) begin
          mem_req_s   = 1'b1;
          mem_we_s    = 1'b0;
          mem_addr_s  = IAddrF;
          mem_wdata_s = {DW{1'b0}};
          dstreak_s   = {SW{1'b0}};
        end else begin
          mem_req_s   = 1'b0;
        end
      end
      IACC: begin
        if (MemAck) begin
          mem_req_s = 1'b0;
          instr_s   = MemRData;
          iready_s  = 1'b1;
        end else if (expired_s) begin
          mem_req_s = 1'b0;
          instr_s   = {DW{1'b0}};
          iready_s  = 1'b1;
          mem_err_s = 1'b1;
        end else begin
          mem_req_s = 1'b1;
        end
      end
      DACC: begin
        if (MemAck) begin
          mem_req_s = 1'b0;
          dready_s  = 1'b1;
          if (!mem_we_r) begin
            drdata_s = MemRData;
          end else begin
            drdata_s = drdata_r;
          end
        end else if (expired_s) begin
          mem_req_s = 1'b0;
          drdata_s  = {DW{1'b0}};
          dready_s  = 1'b1;
          mem_err_s = 1'b1;
        end else begin
          mem_req_s = 1'b1;
        end
      end
      IRSP:    mem_req_s = 1'b0;
      DRSP:    mem_req_s = 1'b0;
      default: mem_req_s = 1'b0;
    endcase
  end

  // Output and streak registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      instr_r     <= {DW{1'b0}};
      drdata_r    <= {DW{1'b0}};
      iready_r    <= 1'b0;
      dready_r    <= 1'b0;
      mem_err_r   <= 1'b0;
      dstreak_r   <= {SW{1'b0}};
    end else begin
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      instr_r     <= instr_s;
      drdata_r    <= drdata_s;
      iready_r    <= iready_s;
      dready_r    <= dready_s;
      mem_err_r   <= mem_err_s;
      dstreak_r   <= dstreak_s;
    end
  end

  assign MemReq    = mem_req_r;
  assign MemWe     = mem_we_r;
  assign MemAddr   = mem_addr_r;
  assign MemWData  = mem_wdata_r;
  assign InstrF    = instr_r;
  assign DRDataM   = drdata_r;
  assign IReadyF   = iready_r;
  assign DReadyM   = dready_r;
  assign MemErr    = mem_err_r;
  assign StallMemF = IReqF & ~iready_r;
  assign StallMemM = DReqM & ~dready_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-level model
// of the arbitration, latency, timeout and reset rules.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        Reset;
  logic        IReqF, DReqM, DWeM, MemAck;
  logic [31:0] IAddrF, DAddrM, DWDataM, MemRData;
  logic [31:0] InstrF, DRDataM, MemAddr, MemWData;
  logic        IReadyF, DReadyM, MemReq, MemWe, StallMemF, StallMemM, MemErr;

  mem_port_arbiter dut (
    .clk(clk), .Reset(Reset),
    .IReqF(IReqF), .IAddrF(IAddrF), .InstrF(InstrF), .IReadyF(IReadyF),
    .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWDataM(DWDataM),
    .DRDataM(DRDataM), .DReadyM(DReadyM),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck),
    .StallMemF(StallMemF), .StallMemM(StallMemM), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Requester-side model state
  bit          ireq, dreq, dwe;
  logic [31:0] iaddr, daddr, dwdata;
  int          exp_streak;
  logic [31:0] last_dr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    IReqF = ireq; IAddrF = iaddr;
    DReqM = dreq; DWeM = dwe; DAddrM = daddr; DWDataM = dwdata;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // One complete access starting in an idle cycle; d = cycles of MemReq before MemAck.
  task automatic transact(input int d, output bit dwin, output bit obs_dwin);
    logic [31:0] rd, exp_addr, exp_wd;
    bit          exp_we;
    apply();
    dwin = dreq && (!ireq || exp_streak < 4);
    rd   = $urandom;
    if (dwin) begin
      exp_addr = daddr; exp_we = dwe; exp_wd = dwdata;
      if (ireq) exp_streak = (exp_streak < 4) ? exp_streak + 1 : 4;
    end else begin
      exp_addr = iaddr; exp_we = 1'b0; exp_wd = 32'h0;
      exp_streak = 0;
    end
    @(negedge clk);
    chk("stall_f_idle", StallMemF, ireq);
    chk("stall_m_idle", StallMemM, dreq);
    next_cycle();
    for (int k = 0; k <= d; k++) begin
      MemAck   = (k == d);
      MemRData = (k == d) ? rd : $urandom;
      @(negedge clk);
      chk("mem_req", MemReq, 1'b1);
      chk("mem_addr", MemAddr, exp_addr);
      chk("mem_we", MemWe, exp_we);
      if (dwin && exp_we) chk("mem_wdata", MemWData, exp_wd);
      chk("early_ready", {IReadyF, DReadyM}, 2'b00);
      next_cycle();
    end
    MemAck = 1'b0; MemRData = $urandom;
    @(negedge clk);
    obs_dwin = DReadyM;
    chk("ready", {IReadyF, DReadyM}, dwin ? 2'b01 : 2'b10);
    chk("mem_req_drop", MemReq, 1'b0);
    chk("mem_err", MemErr, 1'b0);
    if (dwin) begin
      if (!dwe) last_dr = rd;
      chk("drdata", DRDataM, last_dr);
      chk("stall_m_rsp", StallMemM, 1'b0);
    end else begin
      chk("instr", InstrF, rd);
      chk("stall_f_rsp", StallMemF, 1'b0);
    end
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired=1 required=0");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dw, ow;
    int n, hi, guard;
    bit done;

    Reset = 1'b1; MemAck = 1'b0; MemRData = 32'h0;
    ireq = 0; dreq = 0; dwe = 0; iaddr = 0; daddr = 0; dwdata = 0;
    exp_streak = 0; last_dr = 32'h0;
    apply();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {MemReq, MemWe, IReadyF, DReadyM, MemErr}, 5'b0);
    chk("rst_buses", {MemAddr, DRDataM}, 64'h0);
    Reset = 1'b0;
    next_cycle();

    // Fetch only, ack at grant+1
    ireq = 1; iaddr = 32'h40;
    transact(0, dw, ow);
    ireq = 0; apply();

    // Collision: data first, fetch on the cycle after DReadyM
    ireq = 1; iaddr = 32'h44; dreq = 1; dwe = 0; daddr = 32'h100;
    transact(0, dw, ow);
    chk("collision_data_first", ow, 1'b1);
    dreq = 0;
    transact(0, dw, ow);
    chk("collision_fetch_next", ow, 1'b0);
    ireq = 0; apply();

    // Starvation: back-to-back loads while fetch waits
    ireq = 1; iaddr = 32'h48; dreq = 1; dwe = 0;
    n = 0; ow = 1'b1;
    for (int k = 0; k < 8 && ow; k++) begin
      daddr = 32'h1000 + 32'(k * 4);
      transact(1, dw, ow);
      if (ow) n++;
    end
    chk("starve_data_count", n, 4);
    ireq = 0; dreq = 0; apply();

    // Streak cleared: collision goes to data again
    ireq = 1; iaddr = 32'h4C; dreq = 1; daddr = 32'h104;
    transact(0, dw, ow);
    chk("streak_cleared", ow, 1'b1);
    dreq = 0;
    transact(0, dw, ow);
    ireq = 0; apply();

    // Store keeps DRDataM
    dreq = 1; dwe = 1; daddr = 32'h200; dwdata = 32'hDEADBEEF;
    transact(0, dw, ow);
    dwe = 0;

    // Ack on the last allowed cycle beats the timeout
    daddr = 32'h204;
    transact(63, dw, ow);
    dreq = 0; apply();

    // Timeout: MemAck never comes
    dreq = 1; dwe = 0; daddr = 32'h300; apply();
    next_cycle();
    hi = 0; guard = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (MemReq === 1'b1) hi++; else done = 1;
      guard++;
      if (guard > 100) done = 1;
      if (!done) next_cycle();
    end
    chk("timeout_len", hi, 64);
    chk("timeout_pulses", {IReadyF, DReadyM, MemErr}, 3'b011);
    chk("timeout_rdata", DRDataM, 32'h0);
    last_dr = 32'h0;
    dreq = 0; apply();
    next_cycle();
    @(negedge clk);
    chk("timeout_err_one_cycle", {DReadyM, MemErr}, 2'b00);
    next_cycle();

    // MemAck while idle is ignored
    MemAck = 1'b1; MemRData = 32'h12345678;
    @(negedge clk);
    next_cycle();
    MemAck = 1'b0;
    @(negedge clk);
    chk("idle_ack_ignored", {MemReq, IReadyF, DReadyM, MemErr}, 4'b0);
    chk("idle_ack_rdata", DRDataM, last_dr);
    next_cycle();

    // Reset during DACC
    dreq = 1; dwe = 0; daddr = 32'h400; apply();
    next_cycle();
    #2 Reset = 1'b1;
    #1 chk("reset_async_memreq", MemReq, 1'b0);
    dreq = 0; apply();
    next_cycle();
    Reset = 1'b0;
    exp_streak = 0; last_dr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_reset_quiet", {MemReq, IReadyF, DReadyM, MemErr}, 4'b0);
      next_cycle();
    end
    ireq = 1; iaddr = 32'h80;
    transact(0, dw, ow);
    ireq = 0; apply();

    // Randomized traffic
    ireq = 1'($urandom); iaddr = $urandom;
    dreq = 1'($urandom); dwe = 1'($urandom); daddr = $urandom; dwdata = $urandom;
    if (!ireq && !dreq) dreq = 1;
    for (int t = 0; t < 40; t++) begin
      transact(int'($urandom_range(0, 3)), dw, ow);
      if (dw) begin
        dreq = 1'($urandom); dwe = 1'($urandom); daddr = $urandom; dwdata = $urandom;
      end else begin
        ireq = 1'($urandom); iaddr = $urandom;
      end
      if (!ireq && !dreq) ireq = 1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
